// File: rtl/pwm_cfg_pkg.sv
// Shared constants for the PWM configuration sequencer: register map, FSM states, ramp step reset value.
package pwm_cfg_pkg;

    localparam int unsigned ADDR_EN_OUT_LO = 0;
    localparam int unsigned ADDR_EN_OUT_HI = 1;
    localparam int unsigned ADDR_EN_PWM_LO = 2;
    localparam int unsigned ADDR_EN_PWM_HI = 3;
    localparam int unsigned ADDR_DUTY      = 4;
    localparam int unsigned ADDR_RAMP_STEP = 5;

    localparam logic [7:0] RAMP_STEP_RST = 8'h01;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        COMMIT  = 2'd2,
        RAMP    = 2'd3
    } cfg_state_t;

endpackage

// File: rtl/pwm_duty_ramp.sv
// Duty ramp: holds target/step and computes the saturating one-step move toward the target.
// Combinational next value; target loads on load, step on step_wr; no backpressure.
module pwm_duty_ramp
    import pwm_cfg_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] target_in,
    input  logic              step_wr,
    input  logic [DATA_W-1:0] step_in,
    input  logic [DATA_W-1:0] cur_duty,
    output logic [DATA_W-1:0] next_duty,
    output logic              at_target,
    output logic              step_zero
);

    logic [DATA_W-1:0] target_q;
    logic [DATA_W-1:0] step_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            target_q <= '0;
            step_q   <= DATA_W'(RAMP_STEP_RST);
        end else begin
            if (load)
                target_q <= target_in;
            if (step_wr)
                step_q <= step_in;
        end
    end

    // Distance is compared before adding/subtracting so the result never wraps past the target.
    always_comb begin
        next_duty = target_q;
        if (step_q != '0) begin
            if (cur_duty < target_q) begin
                if ((target_q - cur_duty) > step_q)
                    next_duty = cur_duty + step_q;
            end else if ((cur_duty - target_q) > step_q) begin
                next_duty = cur_duty - step_q;
            end
        end
    end

    assign at_target = (next_duty == target_q);
    assign step_zero = (step_q == '0);

endmodule

// File: rtl/pwm_cfg_sequencer.sv
// Shadow/active PWM config bank committed on period_start (active changes one edge later); optional duty ramp under PWM_CFG_RAMP_EN.
// Writes accepted every cycle except the single COMMIT cycle (wr_ready low); bad addresses are consumed and flagged on addr_err.
module pwm_cfg_sequencer
    import pwm_cfg_pkg::*;
#(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8,
    parameter int MAX_ADDR = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              period_start,
    output logic [DATA_W-1:0] en_reg_out_7_0,
    output logic [DATA_W-1:0] en_reg_out_15_8,
    output logic [DATA_W-1:0] en_reg_pwm_7_0,
    output logic [DATA_W-1:0] en_reg_pwm_15_8,
    output logic [DATA_W-1:0] pwm_duty_cycle,
    output logic              update_pending,
    output logic              addr_err
);

`ifdef PWM_CFG_RAMP_EN
    localparam int LAST_ADDR_I = MAX_ADDR + 1;
`else
    localparam int LAST_ADDR_I = MAX_ADDR;
`endif
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LAST_ADDR_I);

    cfg_state_t state;

    logic [DATA_W-1:0] sh_out_lo, sh_out_hi, sh_pwm_lo, sh_pwm_hi, sh_duty;

    logic accept;
    logic addr_ok;
    logic cfg_wr;

    assign wr_ready       = (state != COMMIT);
    assign update_pending = (state != IDLE);
    assign accept         = wr_valid && wr_ready;
    assign addr_ok        = (wr_addr <= LAST_ADDR);
    // The ramp step register is not part of the shadow bank and takes effect immediately.
    assign cfg_wr         = accept && addr_ok && (wr_addr != ADDR_W'(ADDR_RAMP_STEP));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_out_lo <= '0;
            sh_out_hi <= '0;
            sh_pwm_lo <= '0;
            sh_pwm_hi <= '0;
            sh_duty   <= '0;
        end else if (cfg_wr) begin
            case (wr_addr)
                ADDR_W'(ADDR_EN_OUT_LO): sh_out_lo <= wr_data;
                ADDR_W'(ADDR_EN_OUT_HI): sh_out_hi <= wr_data;
                ADDR_W'(ADDR_EN_PWM_LO): sh_pwm_lo <= wr_data;
                ADDR_W'(ADDR_EN_PWM_HI): sh_pwm_hi <= wr_data;
                ADDR_W'(ADDR_DUTY):      sh_duty   <= wr_data;
                default: ;
            endcase
        end
    end

`ifdef PWM_CFG_RAMP_EN
    logic              dirty;
    logic              step_wr;
    logic [DATA_W-1:0] ramp_next;
    logic              ramp_done;
    logic              step_zero;

    assign step_wr = accept && (wr_addr == ADDR_W'(ADDR_RAMP_STEP));

    pwm_duty_ramp #(
        .DATA_W (DATA_W)
    ) u_ramp (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (state == COMMIT),
        .target_in (sh_duty),
        .step_wr   (step_wr),
        .step_in   (wr_data),
        .cur_duty  (pwm_duty_cycle),
        .next_duty (ramp_next),
        .at_target (ramp_done),
        .step_zero (step_zero)
    );
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            addr_err        <= 1'b0;
            en_reg_out_7_0  <= '0;
            en_reg_out_15_8 <= '0;
            en_reg_pwm_7_0  <= '0;
            en_reg_pwm_15_8 <= '0;
            pwm_duty_cycle  <= '0;
`ifdef PWM_CFG_RAMP_EN
            dirty           <= 1'b0;
`endif
        end else begin
            addr_err <= accept && !addr_ok;
            case (state)
                IDLE: begin
                    if (cfg_wr)
                        state <= PENDING;
                end
                PENDING: begin
                    if (period_start)
                        state <= COMMIT;
                end
                COMMIT: begin
                    en_reg_out_7_0  <= sh_out_lo;
                    en_reg_out_15_8 <= sh_out_hi;
                    en_reg_pwm_7_0  <= sh_pwm_lo;
                    en_reg_pwm_15_8 <= sh_pwm_hi;
`ifdef PWM_CFG_RAMP_EN
                    dirty <= 1'b0;
                    if (step_zero || (pwm_duty_cycle == sh_duty)) begin
                        pwm_duty_cycle <= sh_duty;
                        state          <= IDLE;
                    end else begin
                        state <= RAMP;
                    end
`else
                    pwm_duty_cycle <= sh_duty;
                    state          <= IDLE;
`endif
                end
                RAMP: begin
`ifdef PWM_CFG_RAMP_EN
                    if (cfg_wr)
                        dirty <= 1'b1;
                    if (period_start) begin
                        pwm_duty_cycle <= ramp_next;
                        // Shadow edits made while ramping need their own commit.
                        if (ramp_done)
                            state <= (dirty || cfg_wr) ? PENDING : IDLE;
                    end
`else
                    state <= IDLE;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_cfg_sequencer.sv
// Randomized scoreboard bench for pwm_cfg_sequencer; reference model tracks shadow/active banks as plain arrays.
module tb_pwm_cfg_sequencer;

`ifdef PWM_CFG_RAMP_EN
    localparam int MAXA = 5;
`else
    localparam int MAXA = 4;
`endif

    logic       clk;
    logic       rst_n;
    logic       wr_valid;
    logic       wr_ready;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic       period_start;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
    logic       update_pending;
    logic       addr_err;

    pwm_cfg_sequencer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .wr_valid        (wr_valid),
        .wr_ready        (wr_ready),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .period_start    (period_start),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .update_pending  (update_pending),
        .addr_err        (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: registers as arrays, flags for "waiting", "committing", "ramping".
    int sh [6];
    int act [5];
    bit m_pend, m_comm, m_ramp, m_dirty, m_err;
    int m_step, m_tgt;

    logic [42:0] sb_vec [$];
    string       sb_tag [$];
    int tests = 0;
    int fails = 0;
    string phase = "reset";
    int cycle_no = 0;

    function automatic int step_toward(int d, int t, int s);
        if (s == 0) return t;
        if (d < t) return (t - d <= s) ? t : d + s;
        return (d - t <= s) ? t : d - s;
    endfunction

    function automatic logic [42:0] exp_vec();
        return {!m_comm, (m_pend || m_comm || m_ramp), m_err,
                8'(act[4]), 8'(act[3]), 8'(act[2]), 8'(act[1]), 8'(act[0])};
    endfunction

    task automatic model_edge(input bit r, input bit v, input int a, input int d, input bit p);
        bit acc, wr, go;
        int nd;
        m_err = 1'b0;
        if (!r) begin
            foreach (sh[i]) sh[i] = 0;
            foreach (act[i]) act[i] = 0;
            m_pend = 0; m_comm = 0; m_ramp = 0; m_dirty = 0;
            m_step = 1; m_tgt = 0;
            return;
        end
        acc   = v && !m_comm;
        m_err = acc && (a > MAXA);
        wr    = acc && (a <= MAXA);
        if (m_comm) begin
            for (int i = 0; i < 4; i++) act[i] = sh[i];
`ifdef PWM_CFG_RAMP_EN
            m_tgt = sh[4];
            m_dirty = 0;
            if (m_step == 0 || act[4] == m_tgt) act[4] = m_tgt;
            else m_ramp = 1;
`else
            act[4] = sh[4];
`endif
            m_comm = 0;
            m_pend = 0;
        end else if (m_ramp) begin
            nd = step_toward(act[4], m_tgt, m_step);
            if (wr) begin
                if (a == 5) m_step = d;
                else begin sh[a] = d; m_dirty = 1; end
            end
            if (p) begin
                act[4] = nd;
                if (nd == m_tgt) begin m_ramp = 0; m_pend = m_dirty; end
            end
        end else begin
            go = m_pend && p;
            if (wr) begin
                if (a == 5) m_step = d;
                else begin sh[a] = d; m_pend = 1; end
            end
            if (go) m_comm = 1;
        end
    endtask

    // One clock: drive at negedge, model the posedge, queue the expected post-edge outputs.
    task automatic cyc(input bit r, input bit v, input int a, input int d, input bit p);
        @(negedge clk);
        rst_n        = r;
        wr_valid     = v;
        wr_addr      = 7'(a);
        wr_data      = 8'(d);
        period_start = p;
        @(posedge clk);
        model_edge(r, v, a, d, p);
        cycle_no++;
        sb_vec.push_back(exp_vec());
        sb_tag.push_back($sformatf("%s#%0d", phase, cycle_no));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        logic [42:0] got, exp;
        string tag;
        if (sb_vec.size() > 0) begin
            exp = sb_vec.pop_front();
            tag = sb_tag.pop_front();
            got = {wr_ready, update_pending, addr_err, pwm_duty_cycle,
                   en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL %s: got rdy/pend/err=%b%b%b regs=%h  expected rdy/pend/err=%b%b%b regs=%h",
                         tag, got[42], got[41], got[40], got[39:0],
                         exp[42], exp[41], exp[40], exp[39:0]);
            end
        end
    end

    initial begin
        #1000000;
        fails++;
        $display("FAIL timeout: simulation did not finish, %0d tests run", tests);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        bit v, p, r;
        int a, d;
        rst_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; period_start = 1'b0;

        phase = "reset";
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        tests++;
        if (wr_ready !== 1'b1 || update_pending !== 1'b0 || addr_err !== 1'b0 ||
            en_reg_out_7_0 !== 8'h00 || en_reg_out_15_8 !== 8'h00 ||
            en_reg_pwm_7_0 !== 8'h00 || en_reg_pwm_15_8 !== 8'h00 ||
            pwm_duty_cycle !== 8'h00) begin
            fails++;
            $display("FAIL reset state: rdy/pend/err=%b%b%b regs=%h%h%h%h%h",
                     wr_ready, update_pending, addr_err, pwm_duty_cycle,
                     en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0);
        end

        phase = "basic";
        cyc(1, 1, 0, 8'hA5, 0);
        idle(3);
        cyc(1, 0, 0, 0, 1);
        idle(3);

        phase = "merge";
        cyc(1, 1, 2, 8'h0F, 0);
        idle(2);
        cyc(1, 1, 4, 8'h80, 1);
        idle(3);

        phase = "badaddr";
        cyc(1, 1, 8'h10, 8'h55, 0);
        cyc(1, 1, MAXA + 1, 8'h66, 1);
        idle(2);

        phase = "idle_ps";
        cyc(1, 1, 1, 8'h3C, 1);
        idle(2);
        cyc(1, 0, 0, 0, 1);
        idle(2);

        phase = "rst_commit";
        cyc(1, 1, 3, 8'hC3, 0);
        cyc(1, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        idle(2);

`ifdef PWM_CFG_RAMP_EN
        phase = "ramp";
        cyc(1, 1, 5, 8'h30, 0);
        cyc(1, 1, 4, 8'h80, 0);
        cyc(1, 0, 0, 0, 1);
        idle(2);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 0, 1);
            idle(1);
        end
        idle(2);

        phase = "rst_ramp";
        cyc(1, 1, 4, 8'hF0, 0);
        cyc(1, 0, 0, 0, 1);
        idle(2);
        cyc(1, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        idle(2);
`endif

        phase = "random";
        v = 0; a = 0; d = 0;
        for (int i = 0; i < 4000; i++) begin
            if (!(v && m_comm)) begin
                v = ($urandom_range(0, 2) == 0);
                a = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 5));
                d = int'($urandom_range(0, 255));
`ifdef PWM_CFG_RAMP_EN
                if (a == 5) d = int'($urandom_range(0, 3)) * 16'd40;
`endif
            end
            p = ($urandom_range(0, 5) == 0);
            r = ($urandom_range(0, 199) != 0);
            cyc(r, v, a, d & 255, p);
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pwm_cfg_sequencer.md
Name: pwm_cfg_sequencer

Overview:
- Configuration controller between the SPI register interface and the PWM peripheral.
- Accepts register writes into a shadow bank and commits them to the active PWM configuration only at a PWM period boundary, so output enables and duty never change mid-period (glitch-free).
- Optionally ramps duty cycle toward the written target, one step per period.

Parameters:
- ADDR_W, 7, write address width (SPI frame address field).
- DATA_W, 8, register width.
- MAX_ADDR, 4, highest valid configuration address (5 registers, 0x00..0x04).

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- wr_valid  input  1  write request from SPI frame decoder
- wr_ready  output  1  sequencer can accept write this cycle
- wr_addr  input  ADDR_W  register address
- wr_data  input  DATA_W  register data
- period_start  input  1  one-cycle pulse from PWM counter at wrap to 0
- en_reg_out_7_0  output  8  active output enables, bits 7:0
- en_reg_out_15_8  output  8  active output enables, bits 15:8
- en_reg_pwm_7_0  output  8  active PWM-mode enables, bits 7:0
- en_reg_pwm_15_8  output  8  active PWM-mode enables, bits 15:8
- pwm_duty_cycle  output  8  active duty (0x00 = 0%, 0xFF = 100%)
- update_pending  output  1  shadow differs from active and awaits commit
- addr_err  output  1  one-cycle pulse: accepted write had addr > MAX_ADDR

Behaviour:
- Reset (rst_n low at clk edge):
  - All shadow and active registers go to 0x00.
  - State goes to IDLE; update_pending = 0, addr_err = 0, wr_ready = 1.
  - A reset mid-commit or mid-ramp abandons the operation; no partial state survives.
- Address map (shadow):
  - 0x00 en_out_7_0, 0x01 en_out_15_8, 0x02 en_pwm_7_0, 0x03 en_pwm_15_8, 0x04 duty.
- Handshake:
  - A write transfers when wr_valid && wr_ready at a clk edge; the shadow register updates at that edge.
  - wr_ready is low only in the COMMIT state; the writer holds wr_valid/addr/data until accepted.
- Invalid address: the transfer still completes, data is discarded, addr_err pulses the following cycle, and state is unchanged.
- State machine:
  - IDLE: shadow == active. A valid write to 0x00..0x04 goes to PENDING.
  - PENDING: update_pending = 1. On period_start, go to COMMIT. Further writes are accepted and merged into the shadow bank.
  - COMMIT (1 cycle, wr_ready = 0): copy shadow 0x00..0x03 to active and load duty (or the ramp target). Then go to IDLE, or to RAMP when the feature is enabled and active duty != target.
  - RAMP: see Optional Feature.
- Latency: period_start sampled at edge k means active outputs change at edge k+1 and are visible in cycle k+1.
- Simultaneous write and period_start in PENDING: the write is accepted and included in this commit, since the shadow updates at edge k and COMMIT copies at edge k+1.
- A write landing in IDLE in the same cycle as period_start sets PENDING only; commit waits for the next period_start.
- period_start is ignored in IDLE and COMMIT.
- Writing a value equal to the active value still passes through PENDING/COMMIT; there is no compare-to-skip.

Optional Feature:
- Macro: PWM_CFG_RAMP_EN.
- With the macro defined:
  - Address 0x05 is a valid ramp_step register (reset 0x01; MAX_ADDR becomes 5).
  - On COMMIT the duty target is latched. In RAMP, each period_start moves active duty toward the target by ramp_step, saturating exactly at the target (no overshoot, no 8-bit wrap).
  - ramp_step = 0 means an immediate jump to the target.
  - On reaching the target, go to IDLE, or to PENDING if the shadow changed meanwhile.
  - Writes are accepted in RAMP; a new duty write retargets at the next commit.
  - update_pending = 1 during RAMP.
- Without the macro: duty commits directly, RAMP is unreachable, and 0x05 is an invalid address.

Decomposition:
- Shared package pwm_cfg_pkg holds:
  - address constants ADDR_EN_OUT_LO / ADDR_EN_OUT_HI / ADDR_EN_PWM_LO / ADDR_EN_PWM_HI / ADDR_DUTY / ADDR_RAMP_STEP.
  - state enum cfg_state_t {IDLE, PENDING, COMMIT, RAMP}.
  - the ramp_step reset value.
- One natural sub-module, pwm_duty_ramp: saturating step-toward-target arithmetic plus target/step registers. It is instantiated only under PWM_CFG_RAMP_EN.

Test Plan:
- Reset, then write 0x00 = 0xA5 with no period_start: active en_reg_out_7_0 stays 0x00 and update_pending = 1. Pulse period_start: en_reg_out_7_0 = 0xA5 one edge later and update_pending = 0.
- Writes 0x02 = 0x0F and 0x04 = 0x80, with the second write in the same cycle as period_start: both commit together; wr_ready is low for exactly one cycle.
- Write to address 0x10 (0x05 when the macro is off): transfer completes, addr_err pulses once, no state change, and update_pending stays 0.
- PWM_CFG_RAMP_EN, step = 0x30, duty 0x00 → 0x80: successive periods give 0x30, 0x60, 0x80 (saturate), then IDLE.
- Assert rst_n low during COMMIT and during RAMP: the next cycle shows all outputs 0x00, state IDLE, and wr_ready = 1.
